// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter with packet lock
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 4096,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   grant_active,
  output logic                   lock_timeout
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  localparam int             TERM_INT   = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;
  localparam logic [15:0]    TERM       = TERM_INT[15:0];
  localparam bit             TIMEOUT_EN = (LOCK_TIMEOUT != 0);
  localparam logic [IDW-1:0] LAST_RST   = IDW'(NUM_REQ - 1);

  logic [2:0]     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] lastOwner;
  logic           lastFlag;
  logic [15:0]    holdCnt;

  logic [IDW-1:0] winner;
  logic           winFound;
  logic [IDW-1:0] scanIdx;
  int             scan;
  logic           ownerValid;
  logic           holdTerm;

  // Rotating scan starts just after the requester that finished most recently.
  always_comb begin
    winFound = 1'b0;
    winner   = '0;
    scan     = 0;
    scanIdx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = int'(lastOwner) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scanIdx = scan[IDW-1:0];
      if (!winFound && req_valid[scanIdx]) begin
        winFound = 1'b1;
        winner   = scanIdx;
      end
    end
  end

  assign ownerValid   = req_valid[owner];
  assign holdTerm     = TIMEOUT_EN && (holdCnt == TERM);
  assign grant_active = (state != IDLE);

  always_comb begin
    req_ready    = '0;
    tx_start     = 1'b0;
    lock_timeout = 1'b0;
    case (state)
      IDLE: if (winFound && rst_n) req_ready[winner] = 1'b1;
      SEND: tx_start = !tx_busy;
      HOLD: begin
        if (ownerValid) req_ready[owner] = 1'b1;
        else if (holdTerm) lock_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      lastOwner <= LAST_RST;
      lastFlag  <= 1'b0;
      tx_data   <= 8'h00;
      grant_id  <= '0;
      holdCnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (winFound) begin
            owner    <= winner;
            grant_id <= winner;
            tx_data  <= req_data[{winner, 3'b000} +: 8];
            lastFlag <= req_last[winner];
            state    <= SEND;
          end
        end
        SEND: if (!tx_busy) state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (lastFlag) begin
              lastOwner <= owner;
              state     <= IDLE;
            end else begin
              holdCnt <= 16'd0;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // A byte arriving on the terminal-count cycle wins over the timeout.
          if (ownerValid) begin
            tx_data  <= req_data[{owner, 3'b000} +: 8];
            lastFlag <= req_last[owner];
            state    <= SEND;
          end else if (holdTerm) begin
            lastOwner <= owner;
            state     <= IDLE;
          end else if (TIMEOUT_EN) begin
            holdCnt <= holdCnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          grant_active;
  logic          lock_timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .grant_active(grant_active),
    .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         delay;
  } ent_t;

  ent_t       pq[NR][$];
  int         gap[NR];
  bit         flushReq = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         grants[$];
  logic [7:0] startData[$];
  int         startCnt = 0;
  int         acceptCnt = 0;
  int         timeouts = 0;
  int         toDelta = -1;
  int         busyLen = 2;
  bit         randMode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rrPick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // Requester streams: each presents its queue head after a per-entry gap.
  initial begin : stim
    logic [NR-1:0] hs;
    ent_t tmp;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NR; i++) gap[i] = 0;
    forever begin
      @(negedge clk);
      hs = rst_n ? (req_valid & req_ready) : '0;
      @(posedge clk);
      #1;
      if (flushReq) begin
        for (int i = 0; i < NR; i++) begin
          pq[i].delete();
          gap[i] = 0;
        end
        req_valid = '0;
        flushReq  = 1'b0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (hs[i] && req_valid[i]) begin
            if (pq[i].size() > 0) tmp = pq[i].pop_front();
            req_valid[i] = 1'b0;
            gap[i] = 0;
          end
          if (!req_valid[i] && pq[i].size() > 0) begin
            if (gap[i] >= pq[i][0].delay) begin
              req_valid[i]          = 1'b1;
              req_data[8*i +: 8]    = pq[i][0].data;
              req_last[i]           = pq[i][0].last;
              gap[i]                = 0;
            end else begin
              gap[i]++;
            end
          end
        end
      end
    end
  end

  // Transmitter: busy rises the cycle after a start and stays up for a frame.
  initial begin : txm
    int dur;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        dur = randMode ? int'($urandom_range(1, 5)) : busyLen;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (dur) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Reference model: transaction-level arbitration rules checked every cycle.
  initial begin : mon
    bit            locked, pending, arbActive, lastM, arbOpen, expTo;
    int            phase, rrLast, lockOwner, ownerM, holdAge, cyc, doneCycle, w;
    logic [7:0]    expData;
    logic [1:0]    gid;
    logic [NR-1:0] expReady;
    cyc = 0; doneCycle = 0; lockOwner = 0; ownerM = 0;
    locked = 0; pending = 0; arbActive = 0; lastM = 0; phase = 0;
    rrLast = NR - 1; holdAge = 0; expData = 8'h00; gid = 2'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        locked = 0; pending = 0; arbActive = 0; lastM = 0; phase = 0;
        rrLast = NR - 1; holdAge = 0; expData = 8'h00; gid = 2'd0;
        continue;
      end
      arbOpen  = !pending && (phase == 0);
      expReady = '0;
      w        = -1;
      if (arbOpen) begin
        if (locked) begin
          if (req_valid[lockOwner]) w = lockOwner;
        end else begin
          w = rrPick(req_valid, rrLast);
        end
        if (w >= 0) expReady[w] = 1'b1;
      end
      expTo = arbOpen && locked && (w < 0) && (holdAge == TO - 1);
      check("req_ready", 32'(req_ready), 32'(expReady));
      check("tx_start", 32'(tx_start), 32'(pending && !tx_busy));
      check("lock_timeout", 32'(lock_timeout), 32'(expTo));
      check("tx_data", 32'(tx_data), 32'(expData));
      check("grant_id", 32'(grant_id), 32'(gid));
      check("grant_active", 32'(grant_active), 32'(arbActive));
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) grants.push_back(i);
      if (lock_timeout) begin
        timeouts++;
        toDelta = cyc - doneCycle;
      end
      if (tx_start) begin
        startCnt++;
        startData.push_back(tx_data);
      end
      if (pending && !tx_busy) begin
        pending = 0;
        phase   = 1;
      end else if (phase == 1 && tx_busy) begin
        phase = 2;
      end else if (phase == 2 && !tx_busy) begin
        phase     = 0;
        doneCycle = cyc;
        if (lastM) begin
          locked = 0; rrLast = ownerM; arbActive = 0;
        end else begin
          locked = 1; lockOwner = ownerM; holdAge = 0;
        end
      end
      if (w >= 0) begin
        pending = 1; arbActive = 1; ownerM = w; gid = 2'(w);
        expData = req_data[8*w +: 8];
        lastM   = req_last[w];
        acceptCnt++;
      end else if (expTo) begin
        locked = 0; rrLast = lockOwner; arbActive = 0;
      end else if (arbOpen && locked) begin
        holdAge++;
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    check({tag, "_rst_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_rst_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_rst_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_rst_grant_active"}, 32'(grant_active), 32'd0);
    check({tag, "_rst_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rst_lock_timeout"}, 32'(lock_timeout), 32'd0);
  endtask

  task automatic doReset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkResetOutputs(tag);
    flushReq = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    grants.delete();
    startData.delete();
    startCnt = 0;
    timeouts = 0;
    toDelta  = -1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l, input int dly);
    ent_t e;
    e.data = d; e.last = l; e.delay = dly;
    pq[r].push_back(e);
  endtask

  task automatic waitGrants(input int n, input string tag);
    int c = 0;
    while (grants.size() < n && c < 2000) begin
      @(posedge clk);
      c++;
    end
    check({tag, "_grant_wait"}, 32'(grants.size() >= n), 32'd1);
  endtask

  function automatic bit queuesBusy();
    for (int i = 0; i < NR; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitIdle(input string tag);
    int c = 0;
    while (c < 2000 && (grant_active || tx_busy || queuesBusy())) begin
      @(posedge clk);
      c++;
    end
    repeat (2) @(posedge clk);
    check({tag, "_idle_wait"}, 32'(c < 2000), 32'd1);
  endtask

  initial begin : main
    int acceptBase;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 checkResetOutputs("por");
    rst_n = 1'b1;

    // Single byte from requester 2
    doReset("t1");
    push(2, 8'hA5, 1'b1, 0);
    waitGrants(1, "single");
    waitIdle("single");
    check("single_count", 32'(grants.size()), 32'd1);
    check("single_grant", 32'(grants[0]), 32'd2);
    check("single_starts", 32'(startCnt), 32'd1);
    check("single_data", 32'(startData[0]), 32'hA5);

    // Round-robin with all requesters continuously valid
    doReset("t2");
    for (int r = 0; r < NR; r++) begin
      push(r, 8'(8'h20 + r), 1'b1, 0);
      push(r, 8'(8'h30 + r), 1'b1, 0);
    end
    waitGrants(8, "rr");
    for (int k = 0; k < 8; k++) check("rr_order", 32'(grants[k]), 32'(k % NR));
    waitIdle("rr");

    // Packet lock holds off requester 0
    doReset("t3");
    push(1, 8'h10, 1'b0, 0);
    push(1, 8'h11, 1'b0, 0);
    push(1, 8'h12, 1'b1, 0);
    waitGrants(1, "lock_first");
    push(0, 8'h55, 1'b1, 0);
    waitGrants(4, "lock");
    waitIdle("lock");
    for (int k = 0; k < 3; k++) begin
      check("lock_order", 32'(grants[k]), 32'd1);
      check("lock_data", 32'(startData[k]), 32'(8'h10 + k));
    end
    check("lock_after", 32'(grants[3]), 32'd0);

    // Lock timeout, then requester 0 is served
    doReset("t4");
    push(3, 8'hC3, 1'b0, 0);
    waitGrants(1, "to_first");
    push(0, 8'h0F, 1'b1, 0);
    waitGrants(2, "to");
    waitIdle("to");
    check("to_count", 32'(timeouts), 32'd1);
    check("to_delta", 32'(toDelta), 32'(TO));
    check("to_next_grant", 32'(grants[1]), 32'd0);

    // Owner valid on the terminal-count cycle: byte wins, no timeout
    doReset("t5");
    busyLen = 2;
    push(3, 8'h31, 1'b0, 0);
    push(3, 8'h32, 1'b1, 9 + 2);
    waitGrants(2, "coll");
    waitIdle("coll");
    check("coll_timeouts", 32'(timeouts), 32'd0);
    check("coll_grant", 32'(grants[1]), 32'd3);
    check("coll_data", 32'(startData[1]), 32'h32);

    // One cycle later than the terminal count: timeout fires first
    doReset("t5b");
    push(3, 8'h41, 1'b0, 0);
    push(3, 8'h42, 1'b1, 10 + 2);
    waitGrants(2, "late");
    waitIdle("late");
    check("late_timeouts", 32'(timeouts), 32'd1);
    check("late_data", 32'(startData[1]), 32'h42);

    // Reset during WAIT_DONE drops the lock
    doReset("t6");
    busyLen = 6;
    push(1, 8'h77, 1'b0, 0);
    waitGrants(1, "mid");
    begin
      int c = 0;
      while (!tx_busy && c < 100) begin
        @(posedge clk);
        c++;
      end
      check("mid_busy_wait", 32'(c < 100), 32'd1);
    end
    repeat (2) @(posedge clk);
    doReset("mid");
    push(0, 8'hA0, 1'b1, 0);
    push(1, 8'hA1, 1'b1, 0);
    push(2, 8'hA2, 1'b1, 0);
    waitGrants(3, "mid_after");
    for (int k = 0; k < 3; k++) check("mid_order", 32'(grants[k]), 32'(k));
    waitIdle("mid_after");

    // Randomized traffic against the model
    doReset("rand");
    randMode   = 1'b1;
    acceptBase = acceptCnt;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      for (int r = 0; r < NR; r++)
        if (pq[r].size() < 2 && $urandom_range(0, 7) == 0)
          push(r, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 13)));
    end
    waitIdle("rand");
    check("rand_starts", 32'(startCnt), 32'(acceptCnt - acceptBase));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `async_transmitter` between `NUM_REQ` byte-stream requesters. It arbitrates among pending requesters and drives `TxD_start`/`TxD_data` with one-cycle start pulses, tracking `TxD_busy`. It locks the grant for the duration of a multi-byte packet, so bytes from different requesters never interleave. It sits between the on-chip UART clients (debug monitor, console, loader) and the single transmitter instance.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `LOCK_TIMEOUT`, 4096: idle cycles allowed inside a packet before the lock is forcibly released; 0 disables the timeout; maximum 65535.
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i holds a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- `req_last`  in  NUM_REQ  the byte of requester i ends its packet.
- `req_ready`  out  NUM_REQ  combinational accept strobe; the byte transfers on the edge where valid and ready are both high.
- `tx_start`  out  1  to transmitter `TxD_start`; a one-cycle pulse.
- `tx_data`  out  8  to transmitter `TxD_data`; registered.
- `tx_busy`  in  1  from transmitter `TxD_busy`.
- `grant_id`  out  clog2(NUM_REQ)  current/most recent owner; registered.
- `grant_active`  out  1  high whenever the state is not IDLE.
- `lock_timeout`  out  1  one-cycle pulse when a packet lock is forcibly released.

## Operation
- **States:** IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD.
- **Registers:**
  - `owner`
  - `last_owner`
  - `last_flag`
  - `tx_data`
  - 16-bit `hold_cnt`
- **IDLE:**
  - Winner = first i with `req_valid[i]`, scanning from `(last_owner+1) mod NUM_REQ` upward with wrap-around.
  - If a winner exists:
    - `req_ready[winner]`=1 this cycle.
    - On the edge: `owner`<=winner, `grant_id`<=winner, `tx_data`<=its byte, `last_flag`<=its `req_last`.
    - Go to SEND.
- **SEND:**
  - If `tx_busy`=0: `tx_start`=1 for this cycle only, then go to WAIT_BUSY.
  - Otherwise stay with `tx_start`=0. This is a defensive wait; the arbiter never pulses start while the transmitter is busy.
- **WAIT_BUSY:** stay until `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** stay until `tx_busy`=0, then:
  - If `last_flag`=1: `last_owner`<=`owner`, go to IDLE.
  - Otherwise: `hold_cnt`<=0, go to HOLD.
- **HOLD (packet lock):**
  - Only `owner` is served; `req_ready` of all other requesters stays 0.
  - If `req_valid[owner]`: `req_ready[owner]`=1; capture data and last; go to SEND.
  - Otherwise, when `LOCK_TIMEOUT`≠0, increment `hold_cnt`. On the cycle where `hold_cnt`==`LOCK_TIMEOUT`-1 and valid is still low: `lock_timeout`=1, `last_owner`<=`owner`, go to IDLE.
  - If valid and the timeout terminal count coincide, valid wins: the byte is accepted and there is no timeout pulse.
- At most one bit of `req_ready` is high in any cycle. `req_ready` is 0 in SEND, WAIT_BUSY and WAIT_DONE.
- A requester changing `req_data` while valid is high without ready is a protocol error. The arbiter samples data only on the accept edge.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE
  - `tx_start`=0, `tx_data`=0x00
  - `grant_id`=0, `owner`=0
  - `last_owner`=NUM_REQ-1, so requester 0 has first priority
  - `last_flag`=0, `hold_cnt`=0
  - `lock_timeout`=0, `grant_active`=0, `req_ready`=0
- Reset asserted mid-byte drops the lock and any captured byte. A frame already started in the transmitter completes on its own.
- **Latency:** accept edge → `tx_start` high on the next cycle, provided `tx_busy`=0. `TxD_busy` rises 1 cycle after `tx_start`.
- **Gaps:** minimum 2 idle cycles (WAIT_DONE→IDLE/HOLD→SEND) between the transmitter going idle and the next `tx_start`. The serial line gap is therefore negligible.
- `tx_data` is stable from the accept edge until the next accept edge. It is valid throughout the `tx_start` cycle.

## Test plan
- **Single byte:** requester 2 sends 0xA5 with last=1 → one `req_ready[2]` pulse, one `tx_start` with `tx_data`=0xA5, `grant_id`=2; returns to IDLE after `tx_busy` falls.
- **Round-robin:** all four requesters valid continuously, each byte last=1, starting from reset → grant order 0,1,2,3,0,1…. Every requester is served exactly once per 4 bytes.
- **Packet lock:** requester 1 sends 0x10,0x11,0x12 (last only on 0x12) while requester 0 is constantly valid → the three bytes go out contiguously. Requester 0 is granted next. `req_ready[0]` stays 0 during the lock.
- **Lock timeout:** `LOCK_TIMEOUT`=8; requester 3 sends one byte with last=0 then drops valid → `lock_timeout` pulses exactly 8 cycles after entering HOLD. The next grant goes to requester 0 if it is valid.
- **Timeout/valid collision:** owner valid rises on the terminal-count cycle → byte accepted, no `lock_timeout` pulse.
- **Reset mid-packet:** `rst_n` pulsed low during WAIT_DONE → all outputs take their reset values immediately. The first grant after release goes to requester 0.
